// File: rtl/piano_pkg.sv
// piano_pkg: note codes, player states and the octave-4 half-period table shared by the piano blocks.
package piano_pkg;
   localparam int HP_W = 19;
   typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_RELEASE} state_t;
   localparam logic [3:0] NOTE_REST = 4'd0;
   localparam logic [3:0] NOTE_C  = 4'd1;
   localparam logic [3:0] NOTE_CS = 4'd2;
   localparam logic [3:0] NOTE_D  = 4'd3;
   localparam logic [3:0] NOTE_DS = 4'd4;
   localparam logic [3:0] NOTE_E  = 4'd5;
   localparam logic [3:0] NOTE_F  = 4'd6;
   localparam logic [3:0] NOTE_FS = 4'd7;
   localparam logic [3:0] NOTE_G  = 4'd8;
   localparam logic [3:0] NOTE_GS = 4'd9;
   localparam logic [3:0] NOTE_A  = 4'd10;
   localparam logic [3:0] NOTE_AS = 4'd11;
   localparam logic [3:0] NOTE_B  = 4'd12;

   function automatic logic [HP_W-1:0] half_period(input logic [3:0] k);
      case (k)
         NOTE_C:  half_period = 19'd191110;
         NOTE_CS: half_period = 19'd180388;
         NOTE_D:  half_period = 19'd170265;
         NOTE_DS: half_period = 19'd160705;
         NOTE_E:  half_period = 19'd151685;
         NOTE_F:  half_period = 19'd143172;
         NOTE_FS: half_period = 19'd135139;
         NOTE_G:  half_period = 19'd127551;
         NOTE_GS: half_period = 19'd120395;
         NOTE_A:  half_period = 19'd113636;
         NOTE_AS: half_period = 19'd107259;
         NOTE_B:  half_period = 19'd101239;
         default: half_period = '0;
      endcase
   endfunction
endpackage

// File: rtl/note_period_rom.sv
// note_period_rom: maps key/octave to a scaled half-period in clock cycles, floored at 2.
module note_period_rom
   import piano_pkg::*;
#(
   parameter int DIV_SHIFT = 0
) (
   input  logic [3:0]      key_i,
   input  logic [1:0]      octave_i,
   output logic [HP_W-1:0] hp_o,
   output logic            valid_o
);
   logic [HP_W-1:0] base, oct_hp, shr;

   always_comb begin
      base    = half_period(key_i);
      oct_hp  = (octave_i == 2'd0) ? base << 1 : base >> (octave_i - 2'd1);
      shr     = oct_hp >> DIV_SHIFT;
      hp_o    = (shr < HP_W'(2)) ? HP_W'(2) : shr;
      valid_o = (key_i >= NOTE_C) && (key_i <= NOTE_B);
   end
endmodule

// File: rtl/buzzer_tone_gen.sv
// buzzer_tone_gen: square-wave buzzer driver with glitch-free note start, change and stop.
module buzzer_tone_gen
   import piano_pkg::*;
#(
   parameter int DIV_SHIFT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_on,
   input  logic [3:0] key,
   input  logic [1:0] octave,
   output logic       buzzer,
   output logic       playing,
   output logic [3:0] cur_key
);
   state_t          state_q, state_d;
   logic [HP_W-1:0] cnt_q, cnt_d, hp_q, hp_d, rom_hp;
   logic [3:0]      key_q, key_d;
   logic            buz_q, buz_d, rom_valid, req, tgl;

   note_period_rom #(.DIV_SHIFT(DIV_SHIFT)) u_rom (
      .key_i   (key),
      .octave_i(octave),
      .hp_o    (rom_hp),
      .valid_o (rom_valid)
   );

   assign req = key_on & rom_valid;
   assign tgl = cnt_q == hp_q - HP_W'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hp_d    = hp_q;
      buz_d   = buz_q;
      key_d   = key_q;
      if (state_q == ST_IDLE) begin
         if (req) begin
            key_d   = key;
            hp_d    = rom_hp;
            cnt_d   = '0;
            buz_d   = 1'b1;
            state_d = ST_PLAY;
         end
      end else if (!tgl) begin
         cnt_d = cnt_q + HP_W'(1);
      end else begin
         cnt_d = '0;
         buz_d = ~buz_q;
         // RELEASE is only ever entered on a rising toggle, so buz_q=1 here means this toggle ends the note
         if (req) begin
            key_d   = key;
            hp_d    = rom_hp;
            state_d = ST_PLAY;
         end else if (buz_q) begin
            key_d   = NOTE_REST;
            state_d = ST_IDLE;
         end else begin
            state_d = ST_RELEASE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hp_q    <= '0;
         buz_q   <= 1'b0;
         key_q   <= NOTE_REST;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hp_q    <= hp_d;
         buz_q   <= buz_d;
         key_q   <= key_d;
      end
   end

   assign buzzer  = buz_q;
   assign playing = state_q != ST_IDLE;
   assign cur_key = key_q;
endmodule

// File: tb/tb_buzzer_tone_gen.sv
// tb_buzzer_tone_gen: scoreboard bench; each buzzer edge is checked against a queued expected phase.
module tb_buzzer_tone_gen;
   typedef struct {
      logic       lvl;
      bit         chk_len;
      int         len;
      logic [3:0] ck;
      logic       pl;
   } exp_t;

   logic       clk = 0, rst = 1, key_on = 0;
   logic [3:0] key = 0;
   logic [1:0] octave = 0;
   logic       buzzer, playing;
   logic [3:0] cur_key;

   int   n_chk = 0, n_fail = 0, cyc = 0, last_cyc = 0;
   logic prev = 0;
   exp_t exp_q[$];

   buzzer_tone_gen #(.DIV_SHIFT(10)) dut (
      .clk(clk), .rst(rst), .key_on(key_on), .key(key), .octave(octave),
      .buzzer(buzzer), .playing(playing), .cur_key(cur_key)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic lvl, input bit cl, input int len, input logic [3:0] ck, input logic pl);
      exp_t e;
      e.lvl = lvl; e.chk_len = cl; e.len = len; e.ck = ck; e.pl = pl;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (buzzer !== prev) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_edge: buzzer went %0b with no expectation (cycle %0d)", buzzer, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("edge_level", int'(buzzer), int'(e.lvl));
            if (e.chk_len) chk("phase_len", cyc - last_cyc, e.len);
            chk("edge_cur_key", int'(cur_key), int'(e.ck));
            chk("edge_playing", int'(playing), int'(e.pl));
         end
         prev = buzzer;
         last_cyc = cyc;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_buz(input logic v);
      int t = 0;
      @(negedge clk);
      while (buzzer !== v && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (buzzer !== v) begin
         n_chk++;
         n_fail++;
         $display("FAIL wait_buzzer: got %0b expected %0b within 2000 cycles", buzzer, v);
      end
   endtask

   initial begin
      cycles(3);
      chk("reset_buzzer", int'(buzzer), 0);
      chk("reset_playing", int'(playing), 0);
      chk("reset_cur_key", int'(cur_key), 0);
      rst = 0;
      // rests never start a note
      key_on = 1; key = 0;
      cycles(20);
      key = 14;
      cycles(20);
      chk("rest_buzzer", int'(buzzer), 0);
      chk("rest_playing", int'(playing), 0);
      key_on = 0;
      cycles(2);
      // A4 (113636>>10=110), then B4 (101239>>10=98) applied at next toggle, stop from high phase
      push(1, 0, 0, 10, 1); push(0, 1, 110, 10, 1); push(1, 1, 110, 10, 1);
      push(0, 1, 110, 12, 1); push(1, 1, 98, 12, 1); push(0, 1, 98, 0, 0);
      key_on = 1; key = 10; octave = 1;
      wait_buz(1); wait_buz(0); wait_buz(1);
      cycles(5); key = 12;
      wait_buz(0); wait_buz(1);
      cycles(5); key_on = 0;
      wait_buz(0);
      cycles(5);
      chk("stop_playing", int'(playing), 0);
      chk("stop_cur_key", int'(cur_key), 0);
      // C3 (382220>>10=373), then octave 6 (47777>>10=46)
      push(1, 0, 0, 1, 1); push(0, 1, 373, 1, 1); push(1, 1, 373, 1, 1);
      push(0, 1, 46, 1, 1); push(1, 1, 46, 1, 1); push(0, 1, 46, 0, 0);
      key_on = 1; key = 1; octave = 0;
      wait_buz(1); wait_buz(0);
      cycles(5); octave = 3;
      wait_buz(1); wait_buz(0); wait_buz(1);
      cycles(5); key_on = 0;
      wait_buz(0);
      cycles(5);
      // async reset mid-high on E4 (151685>>10=148)
      push(1, 0, 0, 5, 1); push(0, 0, 0, 0, 0);
      key_on = 1; key = 5; octave = 1;
      wait_buz(1);
      cycles(10);
      #1 rst = 1;
      #1;
      chk("async_rst_buzzer", int'(buzzer), 0);
      chk("async_rst_playing", int'(playing), 0);
      chk("async_rst_cur_key", int'(cur_key), 0);
      cycles(2);
      // restart, drop in low phase -> RELEASE, re-request D4 (170265>>10=166) during release
      push(1, 0, 0, 5, 1); push(0, 1, 148, 5, 1); push(1, 1, 148, 5, 1);
      push(0, 1, 148, 3, 1); push(1, 1, 166, 3, 1); push(0, 1, 166, 0, 0);
      rst = 0;
      wait_buz(1); wait_buz(0);
      cycles(5); key_on = 0;
      wait_buz(1);
      cycles(5);
      chk("release_playing", int'(playing), 1);
      key_on = 1; key = 3;
      wait_buz(0); wait_buz(1);
      cycles(5); key_on = 0;
      wait_buz(0);
      cycles(5);
      chk("final_playing", int'(playing), 0);
      chk("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/buzzer_tone_gen.md
# buzzer_tone_gen

Converts the auto-play sequencer's `key_on`/`key` pair (and the same pair from the manual keyboard path) into a square wave for the board's passive buzzer. It sits directly downstream of the auto-play sequencer and upstream of the buzzer pin. It owns the note-to-frequency mapping, octave scaling and click-free start/stop/note-change behaviour. System clock is 100 MHz.

## Interface
- `DIV_SHIFT`, default 0: right-shift applied to every half-period count. Nonzero only in simulation, to shorten waveforms.
- `clk`  input  1  system clock, 100 MHz.
- `rst`  input  1  reset, asynchronous, active-high. Clears every register immediately.
- `key_on`  input  1  note request; high means sound `key`.
- `key`  input  4  note code: 1..12 = C..B chromatic; 0 and 13..15 = rest.
- `octave`  input  2  0 = octave 3, 1 = octave 4 (table base), 2 = octave 5, 3 = octave 6.
- `buzzer`  output  1  square-wave drive to the buzzer pin.
- `playing`  output  1  high whenever the state is not IDLE.
- `cur_key`  output  4  key code currently sounding; 0 when idle.

## Operation
- The half-period table in 100 MHz cycles (octave 4) is fixed as follows:
  - C=191110, C#=180388, D=170265, D#=160705, E=151685, F=143172
  - F#=135139, G=127551, G#=120395, A=113636, A#=107259, B=101239
- Octave scaling of a table value T:
  - octave 0 → T<<1 (maximum 382220; the counter is 19 bits).
  - octave 1 → T.
  - octave 2 → T>>1.
  - octave 3 → T>>2.
  - DIV_SHIFT is then applied as a further right shift. The result is floored at 2.
- A request is valid when `key_on`=1 and `key` is in 1..12.
- There are three states: IDLE, PLAY, RELEASE.
- IDLE:
  - `buzzer`=0, `cur_key`=0, `playing`=0.
  - On a valid request: latch `key`, latch the scaled half-period into `hp`, set `cnt`=0, set `buzzer`=1, go to PLAY.
  - An invalid request (rest or `key_on`=0) keeps the block in IDLE.
- PLAY:
  - `cnt` increments each cycle. When `cnt`==`hp`-1: toggle `buzzer`, set `cnt`=0.
  - At every toggle, the block re-evaluates the inputs:
    - Valid request with a different key or octave: latch the new key and new `hp`. This change takes effect only at the toggle, so no runt pulses are produced.
    - No valid request: go to RELEASE.
- RELEASE:
  - The block keeps counting with the latched `hp` until the next toggle that would drive `buzzer` low.
  - At that point: `buzzer`=0, `cur_key`=0, go to IDLE.
  - If a valid request reappears before that point, the block returns to PLAY at the next toggle. The new key is latched as in PLAY.
  - If the transition to RELEASE happened on a toggle that already drove `buzzer` low, go to IDLE on that same edge.
- Input changes between toggles are ignored. The block samples its inputs only in IDLE (every cycle) and at toggle edges.
- Reset during any state: `buzzer`=0, `playing`=0, `cur_key`=0, `cnt`=0, `hp`=0, state=IDLE, asynchronously. The first request after reset is accepted on the first clock edge at which `rst` is low.

## Timing
- Start latency: a valid request sampled at edge k gives `buzzer`=1 and `playing`=1 after edge k.
- In steady state the output is high for exactly `hp` cycles and low for exactly `hp` cycles.
- Note change latency: at most `hp`(old) cycles; the change applies at the next toggle.
- Stop latency: at most 2·`hp` cycles after the request drops; `buzzer` always ends low.
- The last high phase before stopping is always a full `hp` cycles.
- `playing` falls on the same edge that `buzzer` is driven low for the final time.
- All outputs are registered; there is no combinational path from the inputs to `buzzer`.

## Structure
- Shared package `piano_pkg` holds:
  - the state enum;
  - the note-code constants (`NOTE_REST`=0, C=1 … B=12);
  - the 12-entry half-period constant table;
  - `HP_W`=19.
- The sequencer and the keyboard decoder import the same note codes from this package.
- One sub-module, `note_period_rom`: combinational mapping of (`key`, `octave`, `DIV_SHIFT`) to a scaled half-period, plus a valid flag.
- The top level holds the FSM, `cnt`, `hp` and the output registers.

## Test plan
- Reset, then `key_on`=1, `key`=10 (A), `octave`=1, `DIV_SHIFT`=0 → `buzzer` rises 1 cycle later and toggles every 113636 cycles (440 Hz); `cur_key`=10.
- `DIV_SHIFT`=10, `key`=1, `octave`=0 → half-period 373 cycles (382220>>10). With `octave`=3 → 46 cycles.
- While playing A, switch `key` to 12 mid-half-period → the current phase still lasts the old `hp`. From the next toggle the phases are 101239>>`DIV_SHIFT` cycles.
- Drop `key_on` while `buzzer` is high → the high phase completes, `buzzer` goes low, `playing` falls on that edge, `cur_key`=0.
- `key_on`=1 with `key`=0, then with `key`=14 → the block stays IDLE and `buzzer` stays 0 throughout.
- Assert `rst` mid-high-phase without a clock edge → `buzzer` and `playing` go 0 immediately. After release, re-request `key`=5 → normal start on the next edge.
